// File: rtl/uart_fifo_mmio.sv
// Memory-mapped UART port: RX/TX byte FIFOs, sticky error flags, flush control
// and a free-running cycle counter behind a five-register CPU window.
module uart_fifo_mmio #(
  parameter logic [31:0] ADDR_BASE       = 32'h8000_0000,
  parameter int          RX_DEPTH        = 8,
  parameter int          TX_DEPTH        = 8,
  parameter bit          RX_BACKPRESSURE = 1'b0
) (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic [31:0] Addr,
  input  logic [31:0] WData,
  input  logic [3:0]  WrEn,
  input  logic        RdEn,
  output logic [31:0] RData,
  output logic [7:0]  UartDataIn,
  output logic        UartDataInValid,
  input  logic        UartDataInReady,
  input  logic [7:0]  UartDataOut,
  input  logic        UartDataOutValid,
  output logic        UartDataOutReady
);

  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int RX_CW = RX_AW + 1;
  localparam int TX_CW = TX_AW + 1;

  logic [7:0]       rx_mem [RX_DEPTH];
  logic [7:0]       tx_mem [TX_DEPTH];
  logic [RX_AW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [TX_AW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [RX_CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [TX_CW-1:0] tx_cnt_q, tx_cnt_d;
  logic             rx_ovf_q, rx_ovf_d, tx_drop_q, tx_drop_d;
  logic [31:0]      cyc_q, cyc_d, rdata_q, rdata_d;

  logic sel_status, sel_rx, sel_tx, sel_ctrl, sel_cyc;
  logic wr_any, rd_any, ctrl_wr, flush;
  logic rx_full, rx_empty, tx_full, tx_empty, rx_ready;
  logic rx_push, rx_pop, ovf_set, tx_push, tx_pop, drop_set;
  logic [8:0] rx_cnt_w, tx_cnt_w;
  logic unused_wdata;

  assign sel_status = (Addr == ADDR_BASE);
  assign sel_rx     = (Addr == ADDR_BASE + 32'h04);
  assign sel_tx     = (Addr == ADDR_BASE + 32'h08);
  assign sel_ctrl   = (Addr == ADDR_BASE + 32'h0C);
  assign sel_cyc    = (Addr == ADDR_BASE + 32'h10);

  // A write in the same cycle as a read suppresses the read entirely.
  assign wr_any  = |WrEn;
  assign rd_any  = RdEn && !wr_any;
  assign ctrl_wr = wr_any && sel_ctrl;
  assign flush   = ctrl_wr && WData[2];
  assign unused_wdata = ^WData[31:8];

  assign rx_full  = (rx_cnt_q == RX_CW'(RX_DEPTH));
  assign rx_empty = (rx_cnt_q == '0);
  assign tx_full  = (tx_cnt_q == TX_CW'(TX_DEPTH));
  assign tx_empty = (tx_cnt_q == '0);
  assign rx_ready = RX_BACKPRESSURE ? !rx_full : 1'b1;

  // A full RX still accepts a byte when the head is popped on the same edge.
  assign rx_pop   = rd_any && sel_rx && !rx_empty;
  assign rx_push  = UartDataOutValid && rx_ready && (!rx_full || rx_pop);
  assign ovf_set  = UartDataOutValid && rx_ready && rx_full && !rx_pop;
  assign tx_push  = wr_any && sel_tx && WrEn[0] && !tx_full;
  assign drop_set = wr_any && sel_tx && WrEn[0] && tx_full;
  assign tx_pop   = !tx_empty && UartDataInReady;

  assign rx_cnt_w = 9'(rx_cnt_q);
  assign tx_cnt_w = 9'(tx_cnt_q);

  always_ff @(posedge Clock) begin
    if (rx_push) rx_mem[rx_wr_q] <= UartDataOut;
    if (tx_push) tx_mem[tx_wr_q] <= WData[7:0];
  end

  always_comb begin
    rx_wr_d  = rx_push ? rx_wr_q + RX_AW'(1) : rx_wr_q;
    rx_rd_d  = rx_pop  ? rx_rd_q + RX_AW'(1) : rx_rd_q;
    rx_cnt_d = rx_cnt_q + RX_CW'(rx_push) - RX_CW'(rx_pop);
    tx_wr_d  = tx_push ? tx_wr_q + TX_AW'(1) : tx_wr_q;
    tx_rd_d  = tx_pop  ? tx_rd_q + TX_AW'(1) : tx_rd_q;
    tx_cnt_d = tx_cnt_q + TX_CW'(tx_push) - TX_CW'(tx_pop);
    if (flush) begin
      rx_wr_d  = '0;
      rx_rd_d  = '0;
      rx_cnt_d = '0;
      tx_wr_d  = '0;
      tx_rd_d  = '0;
      tx_cnt_d = '0;
    end
  end

  always_comb begin
    rx_ovf_d  = ovf_set  || (rx_ovf_q  && !(ctrl_wr && WData[0]));
    tx_drop_d = drop_set || (tx_drop_q && !(ctrl_wr && WData[1]));
    cyc_d     = (wr_any && sel_cyc) ? 32'h0 : cyc_q + 32'h1;
  end

  // A counter read returns the value the counter holds after this edge.
  always_comb begin
    rdata_d = '0;
    if (rd_any) begin
      if (sel_status)
        rdata_d = {8'h00, tx_cnt_w[7:0], rx_cnt_w[7:0], 4'h0,
                   tx_drop_q, rx_ovf_q, !rx_empty, !tx_full};
      else if (sel_rx && !rx_empty)
        rdata_d = {24'h0, rx_mem[rx_rd_q]};
      else if (sel_cyc)
        rdata_d = cyc_d;
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      rx_wr_q   <= '0;
      rx_rd_q   <= '0;
      rx_cnt_q  <= '0;
      tx_wr_q   <= '0;
      tx_rd_q   <= '0;
      tx_cnt_q  <= '0;
      rx_ovf_q  <= 1'b0;
      tx_drop_q <= 1'b0;
      cyc_q     <= '0;
      rdata_q   <= '0;
    end else begin
      rx_wr_q   <= rx_wr_d;
      rx_rd_q   <= rx_rd_d;
      rx_cnt_q  <= rx_cnt_d;
      tx_wr_q   <= tx_wr_d;
      tx_rd_q   <= tx_rd_d;
      tx_cnt_q  <= tx_cnt_d;
      rx_ovf_q  <= rx_ovf_d;
      tx_drop_q <= tx_drop_d;
      cyc_q     <= cyc_d;
      rdata_q   <= rdata_d;
    end
  end

  assign RData            = rdata_q;
  assign UartDataIn       = tx_mem[tx_rd_q];
  assign UartDataInValid  = !tx_empty;
  assign UartDataOutReady = rx_ready;

endmodule
